updown_bounce_counter: RTL and testbench
========================================

# updown_bounce_counter

Parametrised ping-pong (bounce) counter: sweeps `cnt` from a runtime lower bound up to a runtime upper bound and back, indefinitely, reversing direction at each bound. Generalises the fixed 3-bit 0↔7 bounce counter to any width, programmable bounds, enable, synchronous load and an optional variable step. Used as a sweep/scan generator for address scanning, PWM triangle carriers and test-pattern sources.

## Interface
- `WIDTH`, 4, counter and bound width in bits (≥2)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `en`  in  1  advance counter this cycle
- `lo`  in  WIDTH  lower bound, unsigned, sampled every cycle
- `hi`  in  WIDTH  upper bound, unsigned, sampled every cycle
- `load`  in  1  synchronous load strobe; priority over `en`
- `load_val`  in  WIDTH  value loaded into `cnt`
- `load_dir`  in  1  direction loaded into `dir` (0 = up, 1 = down)
- `step`  in  WIDTH  increment magnitude; present only with `UDC_STEP_EN`
- `cnt`  out  WIDTH  current count, registered
- `dir`  out  1  direction of the next step, registered (0 = up, 1 = down)
- `turn`  out  1  one-cycle pulse, high in the cycle `cnt` has just landed on a bound and `dir` has flipped
- `err`  out  1  registered flag, high while `hi < lo`

## Operation
- Reset: `cnt`=0, `dir`=0, `turn`=0, `err`=0.
- `err` <= (`hi` < `lo`) every cycle, independent of `en`/`load`.
- Priority per edge: `load` > `err` hold > `en` > idle.
- `load`: `cnt`<=`load_val`, `dir`<=`load_dir`, `turn`<=0. No range check at load.
- `hi` < `lo`: `cnt`, `dir` hold; `turn`<=0.
- `en`=0: `cnt`, `dir` hold; `turn`<=0.
- `en`=1, recovery (out-of-range, e.g. after load or bound change): `cnt` < `lo` → `cnt`<=`lo`, `dir`<=0, `turn`<=0; `cnt` > `hi` → `cnt`<=`hi`, `dir`<=1, `turn`<=0.
- `en`=1, `hi`==`lo`: `cnt`<=`lo`, `dir` holds, `turn`<=0.
- `en`=1, in range, `dir`=0: next = `cnt`+s; if next ≥ `hi` → `cnt`<=`hi`, `dir`<=1, `turn`<=1; else `cnt`<=next.
- `en`=1, in range, `dir`=1: next = `cnt`−s; if next ≤ `lo` (incl. underflow) → `cnt`<=`lo`, `dir`<=0, `turn`<=1; else `cnt`<=next.
- A `cnt` already sitting on a bound with `dir` pointing outward (e.g. loaded) clamps with `turn`=1 and reverses.
- s = 1 without `UDC_STEP_EN`. Sums/differences computed in WIDTH+1 bits; no wrap-around ever reaches `cnt`.
- Steady state with s=1: `lo`,`lo`+1,…,`hi`,`hi`−1,…,`lo`+1,`lo`,…; period 2·(`hi`−`lo`) enabled cycles; each bound visited once per period.

## Timing
- All outputs registered; no combinational input→output path.
- Latency: `en`/`load` at edge N → `cnt`/`dir`/`turn` valid after edge N.
- `turn` coincides with the cycle `cnt` equals the bound; next enabled step moves away.
- `lo`/`hi` changes take effect at the next edge; `err` updates one edge after the bound change.
- `rst` asserted mid-sweep: outputs clear immediately (asynchronous); counting resumes from 0, up, on the first enabled edge after deassertion.

## Configuration
- `UDC_STEP_EN` defined: `step` port exists; s = `step`; `step`=0 → `cnt` holds, `turn`=0 (recovery clamping still applies); overshoot clamps to the bound.
- Not defined: no `step` port; s fixed at 1; logic for variable step absent.

## Test plan
- WIDTH=3, `lo`=0, `hi`=7, `en`=1 from reset → `cnt` 0,1,…,7,6,…,0,1; `turn` high at `cnt`=7 and `cnt`=0 (not the first 0 after reset); period 14.
- `lo`=2, `hi`=5 after reset → first enabled edge `cnt`=2 (recovery, `turn`=0), then 3,4,5(`turn`),4,3,2(`turn`),3.
- `load`=1,`load_val`=6,`load_dir`=0 with `en`=1, `lo`=1,`hi`=4 → `cnt`=6 after load; next edge `cnt`=4,`dir`=1,`turn`=0; then 3.
- `hi`=1,`lo`=3 mid-sweep at `cnt`=2 → `err`=1 next edge, `cnt` frozen at 2; restore `hi`=5 → `err`=0, counting resumes from 2 in the held direction.
- `UDC_STEP_EN`, WIDTH=4, `lo`=0,`hi`=10,`step`=3 → 0,3,6,9,10(`turn`),7,4,1,0(`turn`),3; `step`=0 → hold.
- `rst` pulsed while `cnt`=5, `dir`=1 → `cnt`=0,`dir`=0,`turn`=0,`err`=0 immediately, before next `clk` edge.

Source files
------------

// File: rtl/updown_bounce_counter.sv
// Ping-pong counter sweeping cnt between runtime bounds lo and hi, reversing at each bound.
// Optional feature: define UDC_STEP_EN to add the variable-magnitude step input.
module updown_bounce_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             load_dir,
`ifdef UDC_STEP_EN
  input  logic [WIDTH-1:0] step,
`endif
  output logic [WIDTH-1:0] cnt,
  output logic             dir,
  output logic             turn,
  output logic             err
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  dir_e             dir_q, dir_d;
  logic             turn_q, turn_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   sum, diff;

`ifdef UDC_STEP_EN
  assign s = step;
`else
  assign s = WIDTH'(1);
`endif

  // Extra MSB keeps overflow/underflow visible so the bound clamp catches it.
  assign sum  = {1'b0, cnt_q} + {1'b0, s};
  assign diff = {1'b0, cnt_q} - {1'b0, s};

  always_comb begin
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    turn_d = 1'b0;
    err_d  = (hi < lo);
    if (load) begin
      cnt_d = load_val;
      dir_d = dir_e'(load_dir);
    end else if (err_d) begin
      cnt_d = cnt_q;
    end else if (en) begin
      if (cnt_q < lo) begin
        cnt_d = lo;
        dir_d = DIR_UP;
      end else if (cnt_q > hi) begin
        cnt_d = hi;
        dir_d = DIR_DOWN;
      end else if (hi == lo) begin
        cnt_d = lo;
`ifdef UDC_STEP_EN
      end else if (step == '0) begin
        cnt_d = cnt_q;
`endif
      end else if (dir_q == DIR_UP) begin
        if (sum >= {1'b0, hi}) begin
          cnt_d  = hi;
          dir_d  = DIR_DOWN;
          turn_d = 1'b1;
        end else begin
          cnt_d = sum[WIDTH-1:0];
        end
      end else begin
        if (diff[WIDTH] || (diff[WIDTH-1:0] <= lo)) begin
          cnt_d  = lo;
          dir_d  = DIR_UP;
          turn_d = 1'b1;
        end else begin
          cnt_d = diff[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      dir_q  <= DIR_UP;
      turn_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      turn_q <= turn_d;
      err_q  <= err_d;
    end
  end

  assign cnt  = cnt_q;
  assign dir  = dir_q;
  assign turn = turn_q;
  assign err  = err_q;

endmodule

// File: tb/tb_updown_bounce_counter.sv
// Table-driven bench for updown_bounce_counter with a scoreboard queue of expected outputs.
// Step-feature vectors are included when UDC_STEP_EN is defined.
module tb_updown_bounce_counter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic         load_dir = 1'b0;
  logic [W-1:0] lo = '0;
  logic [W-1:0] hi = '0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] step = '0;
  logic [W-1:0] cnt;
  logic         dir, turn, err;

  always #5 clk = ~clk;

  updown_bounce_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .lo       (lo),
    .hi       (hi),
    .load     (load),
    .load_val (load_val),
    .load_dir (load_dir),
`ifdef UDC_STEP_EN
    .step     (step),
`endif
    .cnt      (cnt),
    .dir      (dir),
    .turn     (turn),
    .err      (err)
  );

  typedef struct {
    string        tag;
    logic         en;
    logic         load;
    logic [W-1:0] load_val;
    logic         load_dir;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [W-1:0] step;
    logic [W-1:0] cnt;
    logic         dir;
    logic         turn;
    logic         err;
  } vec_t;

  vec_t        vecs[$];
  vec_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  function automatic void compare(string tag, logic [W-1:0] ec, logic ed, logic et, logic ee);
    n_checks++;
    if (cnt === ec && dir === ed && turn === et && err === ee)
      n_pass++;
    else
      $display("FAIL %s: got cnt=%0d dir=%0b turn=%0b err=%0b, expected cnt=%0d dir=%0b turn=%0b err=%0b",
               tag, cnt, dir, turn, err, ec, ed, et, ee);
  endfunction

  function automatic void add(string tag, logic e, logic ld, int lv, logic ldd, int l, int h,
                              int st, int c, logic d, logic t, logic er);
    vec_t v;
    v.tag = tag; v.en = e; v.load = ld; v.load_val = W'(lv); v.load_dir = ldd;
    v.lo = W'(l); v.hi = W'(h); v.step = W'(st);
    v.cnt = W'(c); v.dir = d; v.turn = t; v.err = er;
    vecs.push_back(v);
  endfunction

  // Outputs sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    vec_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compare(e.tag, e.cnt, e.dir, e.turn, e.err);
    end
  end

  task automatic run_all();
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      en = vecs[i].en; load = vecs[i].load; load_val = vecs[i].load_val;
      load_dir = vecs[i].load_dir; lo = vecs[i].lo; hi = vecs[i].hi; step = vecs[i].step;
      sb.push_back(vecs[i]);
    end
    @(negedge clk);
    en = 1'b0; load = 1'b0;
    vecs.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; load = 1'b0; rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int p, c;
    #3 compare("reset", 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;

    // Full sweep 0..7: triangle wave with period 14, turn only on bounds after leaving reset.
    for (int k = 1; k <= 16; k++) begin
      p = k % 14;
      c = (p <= 7) ? p : 14 - p;
      add($sformatf("sweep07_%0d", k), 1, 0, 0, 0, 0, 7, 1, c, (p >= 7), (c == 7 || c == 0), 0);
    end
    run_all();

    do_reset();
    add("lo2_rec",  1,0,0,0, 2,5,1, 2,0,0,0);
    add("lo2_3",    1,0,0,0, 2,5,1, 3,0,0,0);
    add("lo2_4",    1,0,0,0, 2,5,1, 4,0,0,0);
    add("lo2_hi",   1,0,0,0, 2,5,1, 5,1,1,0);
    add("lo2_4d",   1,0,0,0, 2,5,1, 4,1,0,0);
    add("lo2_3d",   1,0,0,0, 2,5,1, 3,1,0,0);
    add("lo2_lo",   1,0,0,0, 2,5,1, 2,0,1,0);
    add("lo2_3u",   1,0,0,0, 2,5,1, 3,0,0,0);
    add("lo2_4u",   1,0,0,0, 2,5,1, 4,0,0,0);
    add("lo2_hi2",  1,0,0,0, 2,5,1, 5,1,1,0);
    run_all();

    compare("pre_async_rst", 5, 1, 1, 0);
    #2 rst = 1'b1;
    #1 compare("async_rst", 0, 0, 0, 0);
    #1 rst = 1'b0;
    add("post_rst_1", 1,0,0,0, 0,7,1, 1,0,0,0);
    add("post_rst_2", 1,0,0,0, 0,7,1, 2,0,0,0);
    run_all();

    do_reset();
    add("load6",      1,1,6,0, 1,4,1, 6,0,0,0);
    add("load6_rec",  1,0,0,0, 1,4,1, 4,1,0,0);
    add("load6_3",    1,0,0,0, 1,4,1, 3,1,0,0);
    add("load_hi_up", 1,1,4,0, 1,4,1, 4,0,0,0);
    add("hi_outward", 1,0,0,0, 1,4,1, 4,1,1,0);
    add("hi_out_3",   1,0,0,0, 1,4,1, 3,1,0,0);
    add("en0_hold",   0,0,0,0, 1,4,1, 3,1,0,0);
    add("load14",     1,1,14,0, 0,15,1, 14,0,0,0);
    add("full_hi",    1,0,0,0, 0,15,1, 15,1,1,0);
    add("full_14",    1,0,0,0, 0,15,1, 14,1,0,0);
    add("load0_dn",   1,1,0,1, 0,15,1, 0,1,0,0);
    add("underflow",  1,0,0,0, 0,15,1, 0,0,1,0);
    add("uf_1",       1,0,0,0, 0,15,1, 1,0,0,0);
    add("load1_dn",   1,1,1,1, 0,15,1, 1,1,0,0);
    add("full_lo",    1,0,0,0, 0,15,1, 0,0,1,0);
    add("load_in_err",1,1,7,1, 3,1,1, 7,1,0,1);
    add("err_hold7",  1,0,0,0, 3,1,1, 7,1,0,1);
    run_all();

    do_reset();
    add("err_pre1",   1,0,0,0, 0,5,1, 1,0,0,0);
    add("err_pre2",   1,0,0,0, 0,5,1, 2,0,0,0);
    add("err_set",    1,0,0,0, 3,1,1, 2,0,0,1);
    add("err_hold",   1,0,0,0, 3,1,1, 2,0,0,1);
    add("err_clr",    1,0,0,0, 0,5,1, 3,0,0,0);
    add("err_res4",   1,0,0,0, 0,5,1, 4,0,0,0);
    add("err_res5",   1,0,0,0, 0,5,1, 5,1,1,0);
    add("eq_rec",     1,0,0,0, 3,3,1, 3,1,0,0);
    add("eq_hold",    1,0,0,0, 3,3,1, 3,1,0,0);
    add("eq_hold2",   1,0,0,0, 3,3,1, 3,1,0,0);
    add("eq_widen",   1,0,0,0, 3,6,1, 3,0,1,0);
    add("eq_widen4",  1,0,0,0, 3,6,1, 4,0,0,0);
    run_all();

`ifdef UDC_STEP_EN
    do_reset();
    add("st3_3",   1,0,0,0, 0,10,3, 3,0,0,0);
    add("st3_6",   1,0,0,0, 0,10,3, 6,0,0,0);
    add("st3_9",   1,0,0,0, 0,10,3, 9,0,0,0);
    add("st3_hi",  1,0,0,0, 0,10,3, 10,1,1,0);
    add("st3_7",   1,0,0,0, 0,10,3, 7,1,0,0);
    add("st3_4",   1,0,0,0, 0,10,3, 4,1,0,0);
    add("st3_1",   1,0,0,0, 0,10,3, 1,1,0,0);
    add("st3_lo",  1,0,0,0, 0,10,3, 0,0,1,0);
    add("st3_3b",  1,0,0,0, 0,10,3, 3,0,0,0);
    add("st0_h1",  1,0,0,0, 0,10,0, 3,0,0,0);
    add("st0_h2",  1,0,0,0, 0,10,0, 3,0,0,0);
    run_all();
`endif

    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
